// File: rtl/cmn_bin2onehot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : cmn_bin2onehot_acc
//  Purpose  : Registered multi-channel binary-to-one-hot / thermometer
//             decoder with a valid/ready output stage and a sticky
//             accumulated one-hot mask.
//
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             in_valid      - per-channel index valid      [NUM_CH]
//             in_bin        - packed channel indices       [NUM_CH*BIN_WIDTH]
//             in_mode       - 0 = one-hot, 1 = thermometer
//             in_ready      - a beat can be accepted this cycle
//             acc_clr       - clear the accumulated mask
//             out_valid     - out_vec/out_err hold a result
//             out_ready     - consumer takes the result
//             out_vec       - merged decode of the accepted beat
//             out_err       - a valid channel of the beat was out of range
//             acc_mask      - sticky OR of one-hot decodes since clear/reset
//             acc_full      - every acc_mask bit is set
//
//  Revision : 1.0 - initial release
// ============================================================================
module cmn_bin2onehot_acc #(
    parameter int BIN_WIDTH    = 5,
    parameter int ONEHOT_WIDTH = 32,
    parameter int NUM_CH       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*BIN_WIDTH-1:0]   in_bin,
    input  logic                          in_mode,
    output logic                          in_ready,
    input  logic                          acc_clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ONEHOT_WIDTH-1:0]       out_vec,
    output logic                          out_err,
    output logic [ONEHOT_WIDTH-1:0]       acc_mask,
    output logic                          acc_full
);

    localparam int unsigned c_OH_W = ONEHOT_WIDTH;

    // Indices are widened to 32 bits before comparing so that the range
    // check also works when ONEHOT_WIDTH == 2**BIN_WIDTH (every index legal).
    function automatic logic f_in_range(input logic [BIN_WIDTH-1:0] b);
        return (32'(b) < c_OH_W);
    endfunction

    function automatic logic [ONEHOT_WIDTH-1:0] f_onehot(input logic [BIN_WIDTH-1:0] b);
        logic [ONEHOT_WIDTH-1:0] r;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            r[i] = (32'(b) == 32'(i));
        end
        return r;
    endfunction

    function automatic logic [ONEHOT_WIDTH-1:0] f_therm(input logic [BIN_WIDTH-1:0] b);
        logic [ONEHOT_WIDTH-1:0] r;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            r[i] = (32'(i) <= 32'(b));
        end
        return r;
    endfunction

    logic [ONEHOT_WIDTH-1:0] r_out_vec;
    logic                    r_out_err;
    logic                    r_out_valid;
    logic [ONEHOT_WIDTH-1:0] r_acc_mask;

    logic [ONEHOT_WIDTH-1:0] w_merge_vec;   // per in_mode, goes to out_vec
    logic [ONEHOT_WIDTH-1:0] w_merge_oh;    // always one-hot, feeds acc_mask
    logic                    w_merge_err;
    logic                    w_accept;

    // Merge all channels of the beat. Invalid channels are skipped entirely,
    // so their in_bin value can never raise an error; out-of-range valid
    // channels contribute nothing but the error flag.
    always_comb begin
        w_merge_vec = '0;
        w_merge_oh  = '0;
        w_merge_err = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid[c]) begin
                if (f_in_range(in_bin[c*BIN_WIDTH +: BIN_WIDTH])) begin
                    w_merge_oh  = w_merge_oh | f_onehot(in_bin[c*BIN_WIDTH +: BIN_WIDTH]);
                    w_merge_vec = w_merge_vec |
                                  (in_mode ? f_therm(in_bin[c*BIN_WIDTH +: BIN_WIDTH])
                                           : f_onehot(in_bin[c*BIN_WIDTH +: BIN_WIDTH]));
                end else begin
                    w_merge_err = 1'b1;
                end
            end
        end
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = (|in_valid) && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_vec   <= w_merge_vec;
            r_out_err   <= w_merge_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Clear takes priority over the held value but not over the new beat,
    // so a clear coinciding with an accept leaves exactly that beat's bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_mask <= '0;
        end else begin
            r_acc_mask <= (acc_clr ? '0 : r_acc_mask) | (w_accept ? w_merge_oh : '0);
        end
    end

    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;
    assign out_err   = r_out_err;
    assign acc_mask  = r_acc_mask;
    assign acc_full  = &r_acc_mask;

endmodule
`default_nettype wire

// File: tb/tb_cmn_bin2onehot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmn_bin2onehot_acc
//  Purpose  : Directed self-checking bench for cmn_bin2onehot_acc. A default
//             instance (32 outputs) and a 20-output instance share stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmn_bin2onehot_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [9:0]  in_bin;
    logic        in_mode;
    logic        acc_clr;
    logic        out_ready;

    logic        in_ready,   out_valid,   out_err,   acc_full;
    logic [31:0] out_vec,    acc_mask;
    logic        in_ready20, out_valid20, out_err20, acc_full20;
    logic [19:0] out_vec20,  acc_mask20;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cmn_bin2onehot_acc #(.BIN_WIDTH(5), .ONEHOT_WIDTH(32), .NUM_CH(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bin(in_bin),
        .in_mode(in_mode), .in_ready(in_ready), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_err(out_err), .acc_mask(acc_mask), .acc_full(acc_full)
    );

    cmn_bin2onehot_acc #(.BIN_WIDTH(5), .ONEHOT_WIDTH(20), .NUM_CH(2)) u_dut20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bin(in_bin),
        .in_mode(in_mode), .in_ready(in_ready20), .acc_clr(acc_clr),
        .out_valid(out_valid20), .out_ready(out_ready), .out_vec(out_vec20),
        .out_err(out_err20), .acc_mask(acc_mask20), .acc_full(acc_full20)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] pk(input int b0, input int b1);
        logic [4:0] x0, x1;
        x0 = 5'(b0);
        x1 = 5'(b1);
        return {x1, x0};
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 2'b00;
        in_bin    = '0;
        in_mode   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_vec",   out_vec,        32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_acc_mask",  acc_mask,       32'd0);
        chk("rst_acc_full",  32'(acc_full),  32'd0);

        // Idle: nothing accepted, in_ready stays high.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_out_vec",   out_vec,        32'd0);
            chk("idle_acc_mask",  acc_mask,       32'd0);
            chk("idle_acc_full",  32'(acc_full),  32'd0);
            chk("idle_in_ready",  32'(in_ready),  32'd1);
        end

        // Beat 1: one-hot, bins 3 and 7.
        in_valid = 2'b11; in_bin = pk(3, 7);
        tick();
        chk("b1_out_valid", 32'(out_valid), 32'd1);
        chk("b1_out_vec",   out_vec,        32'h88);
        chk("b1_out_err",   32'(out_err),   32'd0);
        chk("b1_acc_mask",  acc_mask,       32'h88);
        chk("b1_vec20",     32'(out_vec20), 32'h88);

        // Beat 2: only ch0 (bin 0); ch1 holds 31, out of range for the
        // 20-wide instance, but is invalid so must not flag.
        in_valid = 2'b01; in_bin = pk(0, 31);
        tick();
        chk("b2_out_vec",   out_vec,        32'h01);
        chk("b2_acc_mask",  acc_mask,       32'h89);
        chk("b2_err20",     32'(out_err20), 32'd0);

        // Thermometer bin 4: out_vec 0x1F, acc gains only bit 4.
        in_valid = 2'b01; in_bin = pk(4, 0); in_mode = 1'b1;
        tick();
        chk("th_out_vec",   out_vec,        32'h1F);
        chk("th_acc_mask",  acc_mask,       32'h99);
        chk("th_out_err",   32'(out_err),   32'd0);

        // Bins 25 and 2: out of range only for the 20-wide instance.
        in_mode = 1'b0; in_valid = 2'b11; in_bin = pk(25, 2);
        tick();
        chk("oor_vec20",     32'(out_vec20),      32'h4);
        chk("oor_err20",     32'(out_err20),      32'd1);
        chk("oor_acc20",     32'(acc_mask20),     32'h9D);
        chk("oor_noX20",     32'($isunknown({out_vec20, out_err20, acc_mask20, acc_full20, out_valid20, in_ready20})), 32'd0);
        chk("oor_vec32",     out_vec,             32'h0200_0004);
        chk("oor_err32",     32'(out_err),        32'd0);
        chk("oor_acc32",     acc_mask,            32'h0200_009D);

        // No beat with out_ready=1 drains the output.
        in_valid = 2'b00;
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: A (bin 5), then hold with B (bin 9) presented.
        in_valid = 2'b01; in_bin = pk(5, 0);
        tick();
        chk("bpA_out_vec", out_vec, 32'h20);
        in_bin = pk(9, 0); out_ready = 1'b0;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid",    32'(out_valid), 32'd1);
            chk("bp_hold_vec",      out_vec,        32'h20);
            chk("bp_hold_in_ready", 32'(in_ready),  32'd0);
        end
        chk("bp_acc_no_B", acc_mask, 32'h0200_00BD);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", 32'(in_ready), 32'd1);
        tick();
        chk("bpB_out_valid", 32'(out_valid), 32'd1);
        chk("bpB_out_vec",   out_vec,        32'h200);
        chk("bpB_acc",       acc_mask,       32'h0200_02BD);

        // Clear without any accept.
        in_valid = 2'b00; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clr_idle_acc",  acc_mask,       32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);

        // Accumulate bins 0..31 over 16 back-to-back beats.
        in_valid = 2'b11;
        for (int k = 0; k < 16; k++) begin
            in_bin = pk(2 * k, 2 * k + 1);
            tick();
            chk("acc_vec",   out_vec,        32'h3 << (2 * k));
            chk("acc_valid", 32'(out_valid), 32'd1);
            chk("acc_full",  32'(acc_full),  (k == 15) ? 32'd1 : 32'd0);
        end
        chk("acc_all", acc_mask, 32'hFFFF_FFFF);

        // Clear together with a bin-1 beat: clear first, then set.
        in_valid = 2'b01; in_bin = pk(1, 0); acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clracc_mask", acc_mask,       32'h2);
        chk("clracc_full", 32'(acc_full),  32'd0);
        chk("clracc_vec",  out_vec,        32'h2);

        // Duplicate indices set a single bit without error.
        in_valid = 2'b11; in_bin = pk(3, 3);
        tick();
        chk("dup_vec", out_vec,      32'h8);
        chk("dup_err", 32'(out_err), 32'd0);
        chk("dup_acc", acc_mask,     32'hA);

        // Held result, then asynchronous reset between edges.
        in_valid = 2'b01; in_bin = pk(6, 0); out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_vec",   out_vec,        32'd0);
        chk("arst_out_err",   32'(out_err),   32'd0);
        chk("arst_acc_mask",  acc_mask,       32'd0);
        chk("arst_acc_full",  32'(acc_full),  32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
